// File: rtl/sequence_generator_if.sv
// Handshake and serial output bundle of the sequence generator.
// The master side requests transmissions; the slave side is the generator.
interface sequence_generator_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [CNT_W-1:0] repeat_n;
    logic             ready;
    logic             x;
    logic             valid;
    logic             last;
    logic             done;

    modport master (
        output start, pattern, repeat_n,
        input  ready, x, valid, last, done
    );

    modport slave (
        input  start, pattern, repeat_n,
        output ready, x, valid, last, done
    );
endinterface

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: captures a pattern and repeat count on start,
// then shifts it out MSB-first for repeat_n+1 contiguous passes.
module sequence_generator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    sequence_generator_if.slave bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r,    state_s;
    logic [WIDTH-1:0] pattern_r,  pattern_s;
    logic [IDX_W-1:0] bit_idx_r,  bit_idx_s;
    logic [CNT_W-1:0] pass_cnt_r, pass_cnt_s;

    logic ready_r, ready_s;
    logic x_r,     x_s;
    logic valid_r, valid_s;
    logic last_r,  last_s;
    logic done_r,  done_s;

    // Next-state, captured data and next registered outputs.
    always_comb begin
        state_s    = state_r;
        pattern_s  = pattern_r;
        bit_idx_s  = bit_idx_r;
        pass_cnt_s = pass_cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s    = ST_SEND;
                    pattern_s  = bus.pattern;
                    bit_idx_s  = IDX_MAX;
                    pass_cnt_s = bus.repeat_n;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (bit_idx_r != {IDX_W{1'b0}}) begin
                    bit_idx_s = bit_idx_r - IDX_W'(1'b1);
                end else if (pass_cnt_r != {CNT_W{1'b0}}) begin
                    // Next pass starts on the very next cycle, no gap.
                    pass_cnt_s = pass_cnt_r - CNT_W'(1'b1);
                    bit_idx_s  = IDX_MAX;
                end else begin
                    state_s    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Outputs are derived from the upcoming state so they can be registered.
        ready_s = (state_s == ST_IDLE);
        valid_s = (state_s == ST_SEND);
        done_s  = (state_s == ST_DONE);
        if (valid_s) begin
            x_s    = pattern_s[bit_idx_s];
            last_s = (bit_idx_s == {IDX_W{1'b0}}) && (pass_cnt_s == {CNT_W{1'b0}});
        end else begin
            x_s    = 1'b0;
            last_s = 1'b0;
        end
    end

    // State, capture registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            pattern_r  <= {WIDTH{1'b0}};
            bit_idx_r  <= {IDX_W{1'b0}};
            pass_cnt_r <= {CNT_W{1'b0}};
            ready_r    <= 1'b1;
            x_r        <= 1'b0;
            valid_r    <= 1'b0;
            last_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            pattern_r  <= pattern_s;
            bit_idx_r  <= bit_idx_s;
            pass_cnt_r <= pass_cnt_s;
            ready_r    <= ready_s;
            x_r        <= x_s;
            valid_r    <= valid_s;
            last_r     <= last_s;
            done_r     <= done_s;
        end
    end

    assign bus.ready = ready_r;
    assign bus.x     = x_r;
    assign bus.valid = valid_r;
    assign bus.last  = last_r;
    assign bus.done  = done_r;
endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench: per-cycle comparison against a queue-based model of the
// output stream, plus literal expectations for the directed scenarios.
module tb_sequence_generator;
    logic clk;
    logic reset;

    sequence_generator_if #(.WIDTH(8), .CNT_W(4)) if8 ();
    sequence_generator_if #(.WIDTH(4), .CNT_W(2)) if4 ();

    sequence_generator #(.WIDTH(8), .CNT_W(4)) dut8 (.clk(clk), .reset(reset), .bus(if8));
    sequence_generator #(.WIDTH(4), .CNT_W(2)) dut4 (.clk(clk), .reset(reset), .bus(if4));

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected output per cycle: {ready, valid, x, last, done}; empty queue = idle.
    logic [4:0] q8[$];
    logic [4:0] q4[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q8.delete();
            q4.delete();
        end else begin
            if (q8.size() == 0) begin
                if (if8.start) begin
                    for (int p = 0; p <= int'(if8.repeat_n); p++)
                        for (int b = 7; b >= 0; b--)
                            q8.push_back({1'b0, 1'b1, if8.pattern[b],
                                          (p == int'(if8.repeat_n)) && (b == 0), 1'b0});
                    q8.push_back(5'b00001);
                end
            end else begin
                void'(q8.pop_front());
            end
            if (q4.size() == 0) begin
                if (if4.start) begin
                    for (int p = 0; p <= int'(if4.repeat_n); p++)
                        for (int b = 3; b >= 0; b--)
                            q4.push_back({1'b0, 1'b1, if4.pattern[b],
                                          (p == int'(if4.repeat_n)) && (b == 0), 1'b0});
                    q4.push_back(5'b00001);
                end
            end else begin
                void'(q4.pop_front());
            end
        end
    end

    logic [63:0] stream8 = 64'd0;
    logic [63:0] stream4 = 64'd0;
    int nbits8 = 0, nlast8 = 0, ndone8 = 0, last_at8 = 0;
    int nbits4 = 0, nlast4 = 0, ndone4 = 0, last_at4 = 0;

    // Per-cycle compare against the model and stream collection.
    always @(negedge clk) begin
        logic [4:0] e8, e4, a8, a4;
        if (!reset) begin
            e8 = (q8.size() != 0) ? q8[0] : 5'b10000;
            e4 = (q4.size() != 0) ? q4[0] : 5'b10000;
            a8 = {if8.ready, if8.valid, if8.x, if8.last, if8.done};
            a4 = {if4.ready, if4.valid, if4.x, if4.last, if4.done};
            n_cmp += 2;
            if (a8 !== e8) begin
                n_fail++;
                $display("FAIL cycle8 t=%0t: got rvxld=%b expected %b", $time, a8, e8);
            end
            if (a4 !== e4) begin
                n_fail++;
                $display("FAIL cycle4 t=%0t: got rvxld=%b expected %b", $time, a4, e4);
            end
        end
        if (if8.valid) begin
            stream8 = {stream8[62:0], if8.x};
            nbits8++;
            if (if8.last) begin
                nlast8++;
                last_at8 = nbits8;
            end
        end
        if (if8.done) ndone8++;
        if (if4.valid) begin
            stream4 = {stream4[62:0], if4.x};
            nbits4++;
            if (if4.last) begin
                nlast4++;
                last_at4 = nbits4;
            end
        end
        if (if4.done) ndone4++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse8(input logic [7:0] p, input logic [3:0] r);
        @(posedge clk); #2;
        if8.start = 1'b1; if8.pattern = p; if8.repeat_n = r;
        @(posedge clk); #2;
        if8.start = 1'b0;
    endtask

    task automatic pulse4(input logic [3:0] p, input logic [1:0] r);
        @(posedge clk); #2;
        if4.start = 1'b1; if4.pattern = p; if4.repeat_n = r;
        @(posedge clk); #2;
        if4.start = 1'b0;
    endtask

    int b0, d0, l0;

    initial begin
        reset = 1'b1;
        if8.start = 1'b0; if8.pattern = 8'd0; if8.repeat_n = 4'd0;
        if4.start = 1'b0; if4.pattern = 4'd0; if4.repeat_n = 2'd0;
        #12;
        check("reset8_outs", {if8.ready, if8.valid, if8.x, if8.last, if8.done}, 64'h10);
        check("reset4_outs", {if4.ready, if4.valid, if4.x, if4.last, if4.done}, 64'h10);
        #3;
        reset = 1'b0;

        // Single pass
        b0 = nbits8; d0 = ndone8; l0 = nlast8;
        pulse8(8'b0011_0101, 4'd0);
        repeat (12) @(posedge clk); #2;
        check("s1_stream", stream8[7:0], 64'h35);
        check("s1_nbits", nbits8 - b0, 64'd8);
        check("s1_done", ndone8 - d0, 64'd1);
        check("s1_last_cnt", nlast8 - l0, 64'd1);
        check("s1_last_pos", last_at8, nbits8);
        check("s1_ready", if8.ready, 64'd1);

        // Three contiguous passes
        b0 = nbits8; d0 = ndone8; l0 = nlast8;
        pulse8(8'b1011_0000, 4'd2);
        repeat (28) @(posedge clk); #2;
        check("s2_stream", stream8[23:0], 64'hB0B0B0);
        check("s2_nbits", nbits8 - b0, 64'd24);
        check("s2_done", ndone8 - d0, 64'd1);
        check("s2_last_cnt", nlast8 - l0, 64'd1);
        check("s2_last_pos", last_at8, nbits8);

        // Start while busy is ignored (during bit 4 and during DONE)
        b0 = nbits8; d0 = ndone8;
        pulse8(8'b0011_0101, 4'd0);
        repeat (3) @(posedge clk); #2;
        if8.start = 1'b1; if8.pattern = 8'hFF;
        @(posedge clk); #2;
        if8.start = 1'b0;
        repeat (4) @(posedge clk); #2;
        if8.start = 1'b1;
        @(posedge clk); #2;
        if8.start = 1'b0;
        repeat (12) @(posedge clk); #2;
        check("s3_stream", stream8[7:0], 64'h35);
        check("s3_nbits", nbits8 - b0, 64'd8);
        check("s3_done", ndone8 - d0, 64'd1);
        check("s3_ready", if8.ready, 64'd1);

        // Asynchronous reset during the 5th bit
        pulse8(8'h5A, 4'd1);
        repeat (4) @(posedge clk); #3;
        check("s4_busy", if8.valid, 64'd1);
        reset = 1'b1;
        #1;
        check("s4_async_outs", {if8.ready, if8.valid, if8.x, if8.last, if8.done}, 64'h10);
        #4;
        reset = 1'b0;
        b0 = nbits8; d0 = ndone8;
        pulse8(8'h81, 4'd0);
        repeat (12) @(posedge clk); #2;
        check("s4_stream", stream8[7:0], 64'h81);
        check("s4_nbits", nbits8 - b0, 64'd8);
        check("s4_done", ndone8 - d0, 64'd1);

        // start held high: one transaction every 10 cycles
        b0 = nbits8; d0 = ndone8;
        @(posedge clk); #2;
        if8.start = 1'b1; if8.pattern = 8'hA5; if8.repeat_n = 4'd0;
        repeat (40) @(posedge clk); #2;
        if8.start = 1'b0;
        repeat (12) @(posedge clk); #2;
        check("s5_stream", stream8[31:0], 64'hA5A5A5A5);
        check("s5_nbits", nbits8 - b0, 64'd32);
        check("s5_done", ndone8 - d0, 64'd4);

        // Narrow instance at its maximum pass count
        b0 = nbits4; d0 = ndone4; l0 = nlast4;
        pulse4(4'b1001, 2'd3);
        repeat (20) @(posedge clk); #2;
        check("s6_stream", stream4[15:0], 64'h9999);
        check("s6_nbits", nbits4 - b0, 64'd16);
        check("s6_done", ndone4 - d0, 64'd1);
        check("s6_last_cnt", nlast4 - l0, 64'd1);
        check("s6_last_pos", last_at4, nbits4);

        // Wide instance at its maximum pass count
        b0 = nbits8; d0 = ndone8; l0 = nlast8;
        pulse8(8'hC3, 4'hF);
        repeat (135) @(posedge clk); #2;
        check("max_stream", stream8[15:0], 64'hC3C3);
        check("max_nbits", nbits8 - b0, 64'd128);
        check("max_done", ndone8 - d0, 64'd1);
        check("max_last_cnt", nlast8 - l0, 64'd1);

        // Randomized traffic on both instances
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #2;
            if8.start    = ($urandom_range(0, 3) == 0);
            if8.pattern  = 8'($urandom);
            if8.repeat_n = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
            if4.start    = ($urandom_range(0, 2) == 0);
            if4.pattern  = 4'($urandom);
            if4.repeat_n = 2'($urandom);
        end
        if8.start = 1'b0;
        if4.start = 1'b0;
        repeat (140) @(posedge clk); #2;
        check("rand8_ready", if8.ready, 64'd1);
        check("rand4_ready", if4.ready, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
- Serial bit-pattern transmitter that drives the single-bit `x` input of the team's sequence detector.
- Captures a parallel pattern and a repeat count on a start handshake, then shifts the pattern out MSB-first, one bit per clock, back-to-back for (repeat_n+1) passes.
- Used as a synthesizable stimulus source for detector benches and on-chip self-test.

Parameters:
WIDTH, 8, pattern length in bits (>=2)
CNT_W, 4, width of repeat count; up to 2^CNT_W passes

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request to begin transmission; accepted only when ready=1
pattern  input  WIDTH  bits to transmit; pattern[WIDTH-1] sent first
repeat_n  input  CNT_W  extra passes; total passes = repeat_n+1
ready  output  1  high when idle and able to accept start
x  output  1  serial data bit; 0 whenever valid=0
valid  output  1  high in every cycle x carries a pattern bit
last  output  1  high with the final bit of the final pass
done  output  1  one-cycle pulse in the cycle after the last bit

Behaviour:
- All outputs are registered.
- Reset (asynchronous, takes effect immediately, including mid-transmission):
  - State goes to IDLE.
  - ready=1, x=0, valid=0, last=0, done=0.
  - Captured pattern, bit counter and pass counter are cleared.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - ready=1.
  - On the edge where start=1, pattern and repeat_n are latched into internal registers, bit index is set to WIDTH-1, pass counter is set to repeat_n, and the state goes to SEND.
- SEND:
  - The cycle after acceptance: valid=1, x=pattern[WIDTH-1], ready=0.
  - Each subsequent cycle emits the next lower bit.
  - After bit 0 of a pass:
    - If pass counter != 0, decrement it, reload bit index to WIDTH-1 and continue immediately. There is no gap cycle, so successive passes are contiguous.
    - If pass counter == 0, the state goes to DONE.
- last=1 exactly in the cycle where x is bit 0 and pass counter == 0.
- Total valid cycles = WIDTH*(repeat_n+1).
- DONE (one cycle): done=1, valid=0, x=0, ready=0. Next state is IDLE.
- Latency: first bit appears 1 cycle after start is sampled. ready returns 2 cycles after the last bit (one DONE cycle, then IDLE).
- start while ready=0 (SEND or DONE) is ignored and not queued.
- Changes to pattern or repeat_n after acceptance have no effect on the transmission in progress.
- If start is held high continuously, a new transmission is accepted on the first IDLE edge. Steady state is WIDTH*(repeat_n+1)+2 cycles per transaction (DONE cycle plus one IDLE cycle).
- repeat_n at its maximum (2^CNT_W-1) yields 2^CNT_W passes. The pass counter must not wrap.
- Bit index and pass counter never exceed their ranges. Width is clog2(WIDTH) for the bit index, CNT_W for the pass counter.

Test Plan:
1. Reset held for 15 time units, then start=1 for one cycle with pattern=8'b0011_0101, repeat_n=0:
   - x = 0,0,1,1,0,1,0,1 on 8 consecutive cycles with valid=1.
   - last on the 8th bit, done on cycle 9, ready=1 on cycle 10.
2. pattern=8'b1011_0000, repeat_n=2:
   - 24 contiguous valid bits forming 10110000 three times, with no gap.
   - last only on bit 24, then one done pulse.
3. Busy-start rejection, using scenario 1's transmission:
   - Pulse start with pattern=8'hFF during bit 4, and again during the DONE cycle.
   - Output stream is unchanged; no second transmission occurs; ready is still 1 at the end.
4. Mid-transmission reset:
   - Assert reset asynchronously (between clock edges) during the 5th bit of a repeat_n=1 transmission.
   - x, valid, last and done drop to 0 and ready rises to 1 immediately, without waiting for a clock edge.
   - After release, a new start with pattern=8'h81 sends 1,0,0,0,0,0,0,1 correctly.
5. start tied high with pattern=8'hA5, repeat_n=0:
   - Transactions repeat every 10 cycles; each carries 1,0,1,0,0,1,0,1 and is followed by exactly one done pulse.
6. Parameter override WIDTH=4, CNT_W=2, pattern=4'b1001, repeat_n=3:
   - 16 bits of 1001 repeated four times; last on bit 16; pass counter does not wrap.
